// File: rtl/bitwise_pipe.sv
// bitwise_pipe: registered bitwise logic unit.
//
// Each accepted word computes r = (f(op,a,b) & mask) | (a & ~mask) per bit.
// The result goes into a DEPTH-entry output FIFO. Both sides use a
// valid/ready handshake.
//
// Ports:
//   clk, rst_n          rising-edge clock, synchronous active-low reset
//   in_valid/in_ready   operand handshake (op, a, b, mask sampled on accept)
//   out_valid/out_ready result handshake, out = FIFO head (0 when empty)
//   out_zero            out_valid && out == 0
//   xfer_count          completed output handshakes, wraps at 16 bits

// Single-bit lane: applies the selected op, then the mask select.
module bitwise_lane (
  input  logic [2:0] op,
  input  logic       a,
  input  logic       b,
  input  logic       m,
  output logic       r
);
  logic f;

  always_comb begin
    f = 1'b0;
    unique case (op)
      3'b000: f = ~a;
      3'b001: f = a & b;
      3'b010: f = a | b;
      3'b011: f = a ^ b;
      3'b100: f = ~(a & b);
      3'b101: f = ~(a | b);
      3'b110: f = ~(a ^ b);
      3'b111: f = a;
      default: f = 1'b0;
    endcase
  end

  // A masked-off bit passes a through unchanged.
  assign r = m ? f : a;
endmodule

module bitwise_pipe #(
  parameter int WIDTH = 16,
  parameter int DEPTH = 2
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [2:0]       op,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic [WIDTH-1:0] mask,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out,
  output logic             out_zero,
  output logic [15:0]      xfer_count
);
  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  logic [WIDTH-1:0] res;
  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr, rd_ptr;
  logic [CW-1:0]    occ;
  logic             accept, xfer;

  for (genvar i = 0; i < WIDTH; i++) begin : g_lane
    bitwise_lane u_lane (
      .op (op),
      .a  (a[i]),
      .b  (b[i]),
      .m  (mask[i]),
      .r  (res[i])
    );
  end

  // in_ready depends only on registered occupancy and reset. It never
  // looks at out_ready, so a full FIFO refuses input even while draining.
  assign in_ready  = (occ < CW'(DEPTH)) && rst_n;
  assign out_valid = (occ != '0);
  assign accept    = in_valid && in_ready;
  assign xfer      = out_valid && out_ready;

  assign out      = out_valid ? mem[rd_ptr] : '0;
  assign out_zero = out_valid && (out == '0);

  // Storage needs no reset. Entries are only visible through occ.
  always_ff @(posedge clk) begin
    if (accept) mem[wr_ptr] <= res;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      occ        <= '0;
      xfer_count <= '0;
    end else begin
      // DEPTH is a power of two, so pointer overflow is the modulo wrap.
      if (accept) wr_ptr <= wr_ptr + AW'(1);
      if (xfer) begin
        rd_ptr     <= rd_ptr + AW'(1);
        xfer_count <= xfer_count + 16'd1;
      end
      unique case ({accept, xfer})
        2'b10:   occ <= occ + CW'(1);
        2'b01:   occ <= occ - CW'(1);
        default: occ <= occ;
      endcase
    end
  end
endmodule

// File: tb/tb_bitwise_pipe.sv
// Directed testbench for bitwise_pipe (WIDTH=16, DEPTH=2).
// Inputs change 1 time unit after a rising edge. Outputs are checked there too.
module tb_bitwise_pipe;
  logic        clk = 1'b0;
  logic        rst_n;
  logic        in_valid, in_ready;
  logic [2:0]  op;
  logic [15:0] a, b, mask;
  logic        out_valid, out_ready, out_zero;
  logic [15:0] out, xfer_count;

  int          n_tests = 0;
  int          n_fail  = 0;
  logic [15:0] exp_xfer;
  logic [15:0] sweep_exp [8];

  always #5 clk = ~clk;

  bitwise_pipe #(.WIDTH(16), .DEPTH(2)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .op         (op),
    .a          (a),
    .b          (b),
    .mask       (mask),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .out        (out),
    .out_zero   (out_zero),
    .xfer_count (xfer_count)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    n_tests++;
    if (obs !== expv) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, want 0x%0h", tag, obs, expv);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  initial begin
    sweep_exp[0] = 16'hFF00; sweep_exp[1] = 16'h000F;
    sweep_exp[2] = 16'h0FFF; sweep_exp[3] = 16'h0FF0;
    sweep_exp[4] = 16'hFFF0; sweep_exp[5] = 16'hF000;
    sweep_exp[6] = 16'hF00F; sweep_exp[7] = 16'h00FF;

    // Reset with a word offered. The word must not be taken.
    rst_n = 1'b0; in_valid = 1'b1; out_ready = 1'b0;
    op = 3'b111; a = 16'hDEAD; b = 16'h0; mask = 16'hFFFF;
    step(); step();
    chk("rst_out_valid", {31'b0, out_valid}, 0);
    chk("rst_out",       {16'b0, out}, 0);
    chk("rst_xfer",      {16'b0, xfer_count}, 0);
    chk("rst_in_ready",  {31'b0, in_ready}, 0);
    chk("rst_out_zero",  {31'b0, out_zero}, 0);
    rst_n = 1'b1; in_valid = 1'b0; out_ready = 1'b1;
    #1;
    chk("rel_in_ready", {31'b0, in_ready}, 1);
    step();
    chk("rel_no_emit", {31'b0, out_valid}, 0);
    exp_xfer = 16'd0;

    // Op sweep. Occupancy holds at 1 while the next word lands at the head.
    a = 16'h00FF; b = 16'h0F0F; mask = 16'hFFFF; in_valid = 1'b1;
    for (int i = 0; i < 8; i++) begin
      op = 3'(i);
      step();
      chk($sformatf("sweep_out%0d", i), {16'b0, out}, {16'b0, sweep_exp[i]});
      chk($sformatf("sweep_vld%0d", i), {31'b0, out_valid}, 1);
    end
    in_valid = 1'b0;
    step();
    exp_xfer += 16'd8;
    chk("sweep_xfer",  {16'b0, xfer_count}, {16'b0, exp_xfer});
    chk("sweep_empty", {31'b0, out_valid}, 0);

    // Mask cases. NOT 0x00FF is 0xFF00. Masked by 0xF0F0 that gives 0xF000.
    // The unmasked low bits of a (0x000F) pass through, so the result is 0xF00F.
    out_ready = 1'b0; in_valid = 1'b1;
    op = 3'b000; a = 16'h00FF; b = 16'h0000; mask = 16'hF0F0;
    step(); in_valid = 1'b0; #1;
    chk("mask_not", {16'b0, out}, 32'hF00F);
    out_ready = 1'b1; step(); out_ready = 1'b0; in_valid = 1'b1;
    op = 3'b011; a = 16'hFFFF; b = 16'hFFFF; mask = 16'h0000;
    step(); in_valid = 1'b0; #1;
    chk("mask_none",      {16'b0, out}, 32'hFFFF);
    chk("mask_none_zero", {31'b0, out_zero}, 0);
    out_ready = 1'b1; step(); out_ready = 1'b0; in_valid = 1'b1;
    op = 3'b001; a = 16'h1234; b = 16'h0000; mask = 16'hFFFF;
    step(); in_valid = 1'b0; #1;
    chk("and_zero",      {16'b0, out}, 0);
    chk("and_zero_flag", {31'b0, out_zero}, 1);
    out_ready = 1'b1; step();
    exp_xfer += 16'd3;
    chk("mask_xfer", {16'b0, xfer_count}, {16'b0, exp_xfer});

    // Backpressure and full.
    out_ready = 1'b0; in_valid = 1'b1; op = 3'b111; mask = 16'hFFFF;
    a = 16'hA001; step();
    a = 16'hA002; step();
    chk("full_in_ready", {31'b0, in_ready}, 0);
    a = 16'hA003; step();
    chk("full_hold_rdy", {31'b0, in_ready}, 0);
    chk("full_head",     {16'b0, out}, 32'hA001);
    out_ready = 1'b1;
    #1;
    chk("full_rdy_drain", {31'b0, in_ready}, 0);
    step();
    chk("bp_out1",      {16'b0, out}, 32'hA002);
    chk("bp_rdy_again", {31'b0, in_ready}, 1);
    step();
    chk("bp_out2", {16'b0, out}, 32'hA003);
    in_valid = 1'b0;
    step();
    chk("bp_empty", {31'b0, out_valid}, 0);
    exp_xfer += 16'd3;
    chk("bp_xfer", {16'b0, xfer_count}, {16'b0, exp_xfer});

    // Simultaneous push/pop at occupancy 1.
    out_ready = 1'b0; in_valid = 1'b1; a = 16'h0100;
    step();
    out_ready = 1'b1;
    for (int i = 1; i <= 10; i++) begin
      a = 16'h0100 + 16'(i);
      step();
      chk($sformatf("pp_out%0d", i), {16'b0, out}, {16'b0, 16'h0100 + 16'(i)});
      chk($sformatf("pp_rdy%0d", i), {31'b0, in_ready}, 1);
    end
    exp_xfer += 16'd10;
    chk("pp_xfer", {16'b0, xfer_count}, {16'b0, exp_xfer});
    in_valid = 1'b0; step();
    exp_xfer += 16'd1;

    // Stream until xfer_count reaches 0xFFFF with one word left buffered.
    // K streaming edges give K-1 transfers.
    in_valid = 1'b1; a = 16'h5555;
    for (int i = 0; i < 32'(16'hFFFF - exp_xfer) + 1; i++) step();
    chk("pre_wrap", {16'b0, xfer_count}, 32'hFFFF);
    in_valid = 1'b0; step();
    chk("wrap", {16'b0, xfer_count}, 0);

    // Reset mid-stream discards buffered words.
    out_ready = 1'b0; in_valid = 1'b1;
    a = 16'hBEE1; step();
    a = 16'hBEE2; step();
    chk("pre_rst_vld", {31'b0, out_valid}, 1);
    rst_n = 1'b0; step();
    chk("mid_rst_vld", {31'b0, out_valid}, 0);
    chk("mid_rst_out", {16'b0, out}, 0);
    chk("mid_rst_rdy", {31'b0, in_ready}, 0);
    rst_n = 1'b1; in_valid = 1'b0; out_ready = 1'b1;
    step(); step();
    chk("post_rst_vld",  {31'b0, out_valid}, 0);
    chk("post_rst_xfer", {16'b0, xfer_count}, 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
